// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN adds a sub_in port for two's-complement subtraction.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_in,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_q, c_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               sum_bit;
  logic               carry_bit;
  logic [WIDTH-1:0]   b_load;
  logic               c_load;

  // The single shared full-adder cell.
  assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign carry_bit = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so cout=1 means no borrow.
  assign b_load = sub_in ? ~b_in : b_in;
  assign c_load = sub_in ? 1'b1  : cin_in;
`else
  assign b_load = b_in;
  assign c_load = cin_in;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a_in;
          b_sh_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = {sum_bit, s_sh_q[WIDTH-1:1]};
        c_d    = carry_bit;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {sum_bit, s_sh_q[WIDTH-1:1]};
          cout_d  = carry_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum_out     = sum_q;
  assign cout_out    = cout_q;

endmodule
